// File: rtl/gearbox_64b_67b.sv
// gearbox_64b_67b: RX gearbox repacking a 64-bit-per-word bitstream into 67-bit words
//   USER_CLK        in   1   receive user clock, rising edge
//   SYSTEM_RESET_N  in   1   asynchronous active-low reset
//   PASSTHROUGH     in   1   synchronous accumulator clear, suppresses output
//   DATA_IN         in   64  received bits, bit 0 earliest
//   DATA_IN_VALID   in   1   qualifies DATA_IN
//   DATA_OUT        out  67  repacked word, bit 0 earliest
//   DATA_OUT_VALID  out  1   one-cycle strobe per repacked word
//   FILL            out  7   residual bits held in the accumulator
module gearbox_64b_67b (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic        PASSTHROUGH,
    input  logic [63:0] DATA_IN,
    input  logic        DATA_IN_VALID,
    output logic [66:0] DATA_OUT,
    output logic        DATA_OUT_VALID,
    output logic [6:0]  FILL
);
    logic [66:0]  acc;
    logic [6:0]   fill;
    logic [130:0] mask;
    logic [130:0] comb;
    logic         emit;
    // residue bits above fill are stale, so mask them before merging the new word
    always_comb begin
        mask = ~({131{1'b1}} << fill);
        comb = ({64'd0, acc} & mask) | ({67'd0, DATA_IN} << fill);
        emit = fill >= 7'd3;
    end
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            acc            <= '0;
            fill           <= '0;
            DATA_OUT       <= '0;
            DATA_OUT_VALID <= 1'b0;
        end else begin
            DATA_OUT_VALID <= 1'b0;
            if (PASSTHROUGH) begin
                fill <= '0;
            end else if (DATA_IN_VALID) begin
                if (emit) begin
                    DATA_OUT       <= comb[66:0];
                    DATA_OUT_VALID <= 1'b1;
                    acc            <= {3'd0, comb[130:67]};
                    fill           <= fill - 7'd3;
                end else begin
                    acc  <= comb[66:0];
                    fill <= fill + 7'd64;
                end
            end
        end
    end
    assign FILL = fill;
endmodule

// File: tb/tb_gearbox_64b_67b.sv
// tb_gearbox_64b_67b: directed self-checking bench for gearbox_64b_67b
module tb_gearbox_64b_67b;
    logic        USER_CLK;
    logic        SYSTEM_RESET_N;
    logic        PASSTHROUGH;
    logic [63:0] DATA_IN;
    logic        DATA_IN_VALID;
    logic [66:0] DATA_OUT;
    logic        DATA_OUT_VALID;
    logic [6:0]  FILL;
    int          errors;
    int          checks;
    logic [63:0] words [201];

    gearbox_64b_67b dut (
        .USER_CLK       (USER_CLK),
        .SYSTEM_RESET_N (SYSTEM_RESET_N),
        .PASSTHROUGH    (PASSTHROUGH),
        .DATA_IN        (DATA_IN),
        .DATA_IN_VALID  (DATA_IN_VALID),
        .DATA_OUT       (DATA_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .FILL           (FILL)
    );

    initial USER_CLK = 1'b0;
    always #5 USER_CLK = ~USER_CLK;

    // drive one cycle of inputs, then sample 1ns after the rising edge
    task automatic step(input logic v, input logic p, input logic [63:0] d);
        DATA_IN_VALID = v;
        PASSTHROUGH   = p;
        DATA_IN       = d;
        @(posedge USER_CLK);
        #1;
    endtask

    // asynchronous pulse placed between clock edges
    task automatic do_reset();
        SYSTEM_RESET_N = 1'b0;
        #2;
        SYSTEM_RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        SYSTEM_RESET_N = 1'b0;
        step(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++;
        if (DATA_OUT !== 67'd0) begin errors++; $display("FAIL reset_data got %h want 0", DATA_OUT); end
        checks++;
        if (DATA_OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", DATA_OUT_VALID); end
        checks++;
        if (FILL !== 7'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", FILL); end
        SYSTEM_RESET_N = 1'b1;
    endtask

    task automatic test_cadence(input string tag);
        int   n;
        logic ev;
        logic [6:0] ef;
        n = 0;
        for (int k = 1; k <= 67; k++) begin
            step(1'b1, 1'b0, {k[31:0], ~k[31:0]});
            n += int'(DATA_OUT_VALID);
            ev = !(k == 1 || k == 23 || k == 45);
            checks++;
            if (DATA_OUT_VALID !== ev) begin
                errors++;
                $display("FAIL %s_valid input %0d got %b want %b", tag, k, DATA_OUT_VALID, ev);
            end
            if (k == 1 || k == 22 || k == 67) begin
                ef = (k == 1) ? 7'd64 : (k == 22) ? 7'd1 : 7'd0;
                checks++;
                if (FILL !== ef) begin
                    errors++;
                    $display("FAIL %s_fill input %0d got %0d want %0d", tag, k, FILL, ef);
                end
            end
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL %s_count got %0d want 64", tag, n); end
    endtask

    task automatic test_bit_order();
        do_reset();
        step(1'b1, 1'b0, 64'h0);
        checks++;
        if (DATA_OUT_VALID !== 1'b0 || FILL !== 7'd64) begin
            errors++;
            $display("FAIL bitorder_first got valid=%b fill=%0d want valid=0 fill=64", DATA_OUT_VALID, FILL);
        end
        step(1'b1, 1'b0, 64'h7);
        checks++;
        if (DATA_OUT !== 67'h7_0000_0000_0000_0000 || DATA_OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL bitorder_data got %h/%b want 70000000000000000/1", DATA_OUT, DATA_OUT_VALID);
        end
        checks++;
        if (FILL !== 7'd61) begin errors++; $display("FAIL bitorder_fill got %0d want 61", FILL); end
    endtask

    task automatic test_stream(input bit gapped);
        logic        q[$];
        logic [66:0] prev;
        logic [66:0] exp;
        int          idx;
        int          cyc;
        int          nout;
        string       tag;
        tag  = gapped ? "gapped" : "stream";
        idx  = 0;
        cyc  = 0;
        nout = 0;
        do_reset();
        while (idx < 201 && cyc < 1000) begin
            prev = DATA_OUT;
            if (gapped && cyc % 3 == 2) begin
                step(1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);
                checks++;
                if (DATA_OUT_VALID !== 1'b0 || DATA_OUT !== prev) begin
                    errors++;
                    $display("FAIL %s_idle cycle %0d got valid=%b data=%h want valid=0 data=%h", tag, cyc, DATA_OUT_VALID, DATA_OUT, prev);
                end
            end else begin
                step(1'b1, 1'b0, words[idx]);
                for (int i = 0; i < 64; i++) q.push_back(words[idx][i]);
                idx++;
                if (DATA_OUT_VALID === 1'b1) begin
                    nout++;
                    checks++;
                    if (q.size() < 67) begin
                        errors++;
                        $display("FAIL %s_underrun word %0d got %0d bits queued want >=67", tag, nout, q.size());
                    end else begin
                        for (int i = 0; i < 67; i++) exp[i] = q.pop_front();
                        if (DATA_OUT !== exp) begin
                            errors++;
                            $display("FAIL %s_word %0d got %h want %h", tag, nout, DATA_OUT, exp);
                        end
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (nout != 192) begin errors++; $display("FAIL %s_count got %0d want 192", tag, nout); end
        checks++;
        if (FILL !== 7'd0 || q.size() != 0) begin
            errors++;
            $display("FAIL %s_residue got fill=%0d queued=%0d want 0/0", tag, FILL, q.size());
        end
    endtask

    task automatic test_passthrough();
        logic [66:0] prev;
        logic [63:0] a;
        logic [63:0] b;
        a = 64'hA5A5_0123_4567_89AB;
        b = 64'hFEDC_BA98_7654_3215;
        do_reset();
        for (int k = 1; k <= 9; k++) step(1'b1, 1'b0, {8{k[7:0]}});
        checks++;
        if (FILL !== 7'd40) begin errors++; $display("FAIL pass_prefill got %0d want 40", FILL); end
        prev = DATA_OUT;
        step(1'b1, 1'b1, 64'h1111_2222_3333_4444);
        checks++;
        if (DATA_OUT_VALID !== 1'b0 || DATA_OUT !== prev) begin
            errors++;
            $display("FAIL pass_hold got valid=%b data=%h want 0/%h", DATA_OUT_VALID, DATA_OUT, prev);
        end
        step(1'b0, 1'b1, 64'h5555_6666_7777_8888);
        checks++;
        if (DATA_OUT_VALID !== 1'b0 || DATA_OUT !== prev || FILL !== 7'd0) begin
            errors++;
            $display("FAIL pass_clear got valid=%b data=%h fill=%0d want 0/%h/0", DATA_OUT_VALID, DATA_OUT, FILL, prev);
        end
        step(1'b1, 1'b0, a);
        checks++;
        if (DATA_OUT_VALID !== 1'b0 || FILL !== 7'd64) begin
            errors++;
            $display("FAIL pass_a got valid=%b fill=%0d want 0/64", DATA_OUT_VALID, FILL);
        end
        step(1'b1, 1'b0, b);
        checks++;
        if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== {b[2:0], a}) begin
            errors++;
            $display("FAIL pass_b got %b/%h want 1/%h", DATA_OUT_VALID, DATA_OUT, {b[2:0], a});
        end
        checks++;
        if (FILL !== 7'd61) begin errors++; $display("FAIL pass_fill got %0d want 61", FILL); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, {~k[31:0], k[31:0]});
        checks++;
        if (DATA_OUT_VALID !== 1'b1 || FILL !== 7'd37) begin
            errors++;
            $display("FAIL areset_pre got valid=%b fill=%0d want 1/37", DATA_OUT_VALID, FILL);
        end
        #3;
        SYSTEM_RESET_N = 1'b0;
        #1;
        checks++;
        if (DATA_OUT !== 67'd0 || DATA_OUT_VALID !== 1'b0 || FILL !== 7'd0) begin
            errors++;
            $display("FAIL areset_clear got data=%h valid=%b fill=%0d want 0/0/0", DATA_OUT, DATA_OUT_VALID, FILL);
        end
        #1;
        SYSTEM_RESET_N = 1'b1;
        test_cadence("areset_cadence");
    endtask

    initial begin
        logic [30:0] s;
        logic        nb;
        errors = 0;
        checks = 0;
        SYSTEM_RESET_N = 1'b1;
        PASSTHROUGH    = 1'b0;
        DATA_IN_VALID  = 1'b0;
        DATA_IN        = '0;
        s = 31'h1234_5678;
        for (int w = 0; w < 201; w++) begin
            for (int b = 0; b < 64; b++) begin
                nb = s[30] ^ s[27];
                s = {s[29:0], nb};
                words[w][b] = nb;
            end
        end
        test_reset();
        test_cadence("cadence");
        test_bit_order();
        test_stream(1'b0);
        test_stream(1'b1);
        test_passthrough();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gearbox_64b_67b.md
# gearbox_64B_67B

RX-side gearbox between the 64-bit transceiver parallel interface and the 64B/67B block decoder. It repacks a continuous bitstream delivered as 64-bit words into 67-bit words with a qualifying valid strobe: 64 output words per 67 input words. It does no block alignment. The downstream decoder finds the 67-bit block boundary itself by sliding across two consecutive output words, so this block only has to preserve bit order and never drop or duplicate a bit.

## Interface
- No parameters; widths fixed at 64 in / 67 out.
- USER_CLK  input  1  receive user clock; all logic on rising edge.
- SYSTEM_RESET_N  input  1  reset, asynchronous, active-low.
- PASSTHROUGH  input  1  synchronous clear of the accumulator while high; no output words produced.
- DATA_IN  input  64  received bits; bit 0 is earliest in time.
- DATA_IN_VALID  input  1  qualifies DATA_IN; when low the cycle is ignored.
- DATA_OUT  output  67  repacked word; bit 0 is earliest in time; feeds decoder DATA_IN.
- DATA_OUT_VALID  output  1  one-cycle strobe; feeds decoder DATA_IN_VALID.
- FILL  output  7  residual bits held in the accumulator (0..66), for debug.

## Operation
- State:
  - 67-bit residue register `acc`; only bits [fill-1:0] are meaningful, the rest are don't-care.
  - 7-bit `fill` counter.
- Accepted input (DATA_IN_VALID=1, PASSTHROUGH=0):
  - Form the combined vector `comb = acc[fill-1:0] | (DATA_IN << fill)`, width 131.
  - Form `total = fill + 64`, range 64..130.
- If `total >= 67` (equivalently `fill >= 3`):
  - Emit `comb[66:0]`.
  - Set `acc <= comb >> 67`.
  - Set `fill <= fill - 3`.
- Else (`fill` is 0..2):
  - No emit.
  - Set `acc <= comb[66:0]`.
  - Set `fill <= fill + 64`, giving 64..66.
- At most one word is emitted per input; an output word can never be pending without an input.
- From `fill=0`, the steady-state cadence has stalls on input words 1, 23 and 45 of every 67-word period. Each period yields exactly 64 outputs.
- DATA_IN_VALID=0: `acc`, `fill` and `DATA_OUT` hold; DATA_OUT_VALID=0.
- PASSTHROUGH=1:
  - `fill <= 0`; `acc` contents are don't-care.
  - DATA_OUT_VALID=0 and DATA_OUT holds, regardless of DATA_IN_VALID.
  - The first accepted input after deassertion restarts the cadence as from reset.
- Width rules:
  - `fill` arithmetic is unsigned 7-bit.
  - Shifts are logical with zero fill.
  - Unused high bits of `acc` must not leak into DATA_OUT; `comb` masks `acc` to `fill` bits.

## Timing
- Reset (SYSTEM_RESET_N low, asynchronous): DATA_OUT=67'd0, DATA_OUT_VALID=0, FILL=0, `acc`=0.
- Release of reset takes effect at the first USER_CLK edge with SYSTEM_RESET_N high. The release must be synchronised externally.
- Latency: an emitting input sampled at edge N gives DATA_OUT/DATA_OUT_VALID at edge N, visible in cycle N+1.
- DATA_OUT changes only on valid cycles. DATA_OUT_VALID is high for exactly one cycle per word.
- FILL reflects the registered `fill` and updates on the same edge as DATA_OUT.
- Reset asserted mid-stream: all state is cleared immediately and any partial residue is discarded.
- Throughput: one input per clock sustained, with no back-pressure; the downstream decoder always accepts.

## Test plan
- **Cadence.** Reset, then 67 back-to-back valid inputs.
  - Exactly 64 DATA_OUT_VALID pulses.
  - Stalls follow inputs 1, 23 and 45.
  - FILL after input 1 = 64, after input 22 = 1, after input 67 = 0.
- **Bit order.** Input 0 = 64'h0, input 1 = 64'h7.
  - First output = 67'h7_0000_0000_0000_0000, i.e. bits [66:64]=3'b111.
  - FILL=61.
- **Continuity.** Feed a 201-word stream of a 31-bit PRBS.
  - Concatenating DATA_OUT words LSB-first reproduces the input bitstream exactly, with no slips.
- **Gapped valid.** Same stream as above, with DATA_IN_VALID low on every third cycle.
  - Output bitstream is identical to the continuity case.
  - No strobe appears in any cycle following an idle cycle.
- **Passthrough.** Assert PASSTHROUGH for 2 cycles at FILL=40, then resume with inputs A and B.
  - No output on A.
  - Output on B = {B[2:0], A}.
- **Async reset mid-stream.** Pulse SYSTEM_RESET_N low between clock edges.
  - Outputs are 0 before the next edge.
  - Restarts with the cadence of the first test.
